control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Hardwired fetch/decode/execute sequencer directly upstream of data_path. Generates every
//  bus-out select, register-in enable, ALU op, and memory strobe for one instruction at a time.
//  Decodes from the IR contents fed back by the datapath.
//  Moore FSM: outputs are combinational from the state register plus ir.
// PARAMETERS
//  ALU_ADD         5'b00011  ALU op code driven on op for address/immediate adds
//  ILLEGAL_AS_NOP  1         1: undefined opcode retires as NOP; 0: undefined opcode enters HALT
// PORTS
//  clock     in   1   system clock, rising edge
//  clear     in   1   synchronous active-high reset
//  stop      in   1   pause request; sampled only in T0
//  ir        in   32  instruction register: opc=ir[31:27] ra=ir[26:23] rb=ir[22:19] rc=ir[18:15]
//  reg_in    out  16  one-hot Rin enables, R0..R15
//  reg_out   out  16  one-hot Rout selects, R0..R15
//  PCout,PCin,IncPC,MARin,MDRin,MDRout,Yin,Zhighin,Zlowin,Zhighout,Zlowout,HIin,LOin,
//  IRin,Cout,BAOut,Read,Write  out 1 each   datapath strobes; Cout drives sign-extended ir[18:0]
//  op        out  5   ALU operation
//  run       out  1   1 while executing; 0 in HALT or while paused
//  illegal   out  1   1-cycle pulse in T3 when opc is undefined
// BEHAVIOUR
//  States: RST,T0..T7,PAUSE,HALT. clear=1 -> RST on next edge, regardless of current state.
//  In RST: all outputs 0, run=1. RST->T0 unconditionally.
//  Any output not listed for a state is 0. At most one bus driver is asserted per cycle.
//  T0: stop=1 -> PAUSE (no strobes, run=0). PAUSE->T0 once stop=0.
//      Otherwise PCout,MARin,IncPC,Zlowin -> T1.
//  T1: Zlowout,PCin,Read,MDRin -> T2.   T2: MDRout,IRin -> T3. ir is valid from T3 on.
//  opc map:
//   00000-01011  R-type: Ra<=Rb op Rc, with op=opc
//   01110 mul, 01111 div
//   10000 ld, 10001 st, 10010 addi
//   11010 nop, 11011 halt; all other codes undefined
//  R-type/mul/div:
//   T3: reg_out[rb],Yin.  T4: reg_out[rc],op=opc,Zlowin,Zhighin.
//   R-type T5: Zlowout,reg_in[ra] -> T0.
//   mul/div T5: Zlowout,LOin.  T6: Zhighout,HIin -> T0.
//  ld/st/addi base phase:
//   T3: reg_out[rb],BAOut,Yin (BAOut forces R0 to read as 0).  T4: Cout,op=ALU_ADD,Zlowin.
//   addi T5: Zlowout,reg_in[ra] -> T0.
//   ld T5: Zlowout,MARin.  T6: Read,MDRin.  T7: MDRout,reg_in[ra] -> T0.
//   st T5: Zlowout,MARin.  T6: reg_out[ra],MDRin.  T7: MDRout,Write -> T0.
//  nop: T3 -> T0.  halt: T3 -> HALT. HALT holds with run=0 and all strobes 0 until clear.
//  Undefined opc: illegal=1 in T3; then T0 if ILLEGAL_AS_NOP else HALT.
//  Cycles per instruction, counted from T0 through the last execute state:
//   nop 4, R-type/addi 6, mul/div 7, ld/st 8.
//  The datapath holds ir stable from T3 through the next T2; this block does not latch ir.
//  ra=rb=rc=0 is legal: R-type drives reg_out[0] without BAOut, so the true R0 value is used.
//  clear during T6 of st: Write is never asserted, and the sequence restarts at RST then T0.
// TESTING
//  1. clear=1 for 2 cycles, then 0 -> RST then T0; cycle 1 after release PCout=MARin=IncPC=1;
//     all other outputs 0 during clear.
//  2. ir=0x1A9B_8000 (opc 00011, ra=5, rb=3, rc=7) -> T3 reg_out=0x0008; T4 reg_out=0x0080,
//     op=00011; T5 reg_in=0x0020, Zlowout=1; next cycle T0.
//  3. ld, ir=0x8088_0010 (ra=1, rb=1, C=16) -> T3 BAOut=1, reg_out=0x0002; T4 Cout=1, op=ALU_ADD;
//     T6 Read=1; T7 reg_in=0x0002; 8 cycles total.
//  4. st, then assert clear in T6 -> Write never goes high; next state RST.
//  5. halt (opc 11011) -> run=0 from the cycle after T3 and held for 20 cycles;
//     stop=1 at T0 -> PAUSE, with no strobes until stop drops.
//  6. opc 11111, ILLEGAL_AS_NOP=1 -> illegal pulses 1 cycle in T3, then T0;
//     with ILLEGAL_AS_NOP=0 -> HALT.

Source files
------------

// File: rtl/control_unit.sv
// control_unit
//   Hardwired fetch/decode/execute sequencer that sits directly upstream of
//   data_path. It runs one instruction at a time. For each step it drives the
//   bus-out selects, the register-in enables, the ALU op and the memory strobes.
//   The instruction is decoded from the IR contents that the datapath feeds back.
//   This is a Moore machine: the outputs depend only on the state register and
//   on ir. The stop and clear inputs affect only the next state.
//
// Ports
//   clock        in   1   system clock, rising edge
//   clear        in   1   synchronous active-high reset (goes to RST)
//   stop         in   1   pause request, looked at only in T0
//   ir           in   32  opc=ir[31:27] ra=ir[26:23] rb=ir[22:19] rc=ir[18:15]
//   reg_in       out  16  one-hot register-in enables R0..R15
//   reg_out      out  16  one-hot register-out selects R0..R15
//   PCout..Write out  1   datapath strobes; Cout drives sign-extended ir[18:0]
//   op           out  5   ALU operation
//   run          out  1   1 while sequencing; 0 in HALT or PAUSE
//   illegal      out  1   single-cycle pulse in T3 for an undefined opcode
//   state_dbg    out  4   current state register, for observation only
//
// Handshake: none. The datapath holds ir stable from T3 through the following
// T2. This block never latches ir.
module control_unit #(
  parameter logic [4:0] ALU_ADD        = 5'b00011,
  parameter bit         ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        stop,
  input  logic [31:0] ir,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Yin,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        IRin,
  output logic        Cout,
  output logic        BAOut,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  op,
  output logic        run,
  output logic        illegal,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  state_t state, state_nxt;

  // Instruction fields
  logic [4:0]  opc;
  logic [15:0] ra_1h, rb_1h, rc_1h;
  logic        is_rtype, is_muldiv, is_ld, is_st, is_addi, is_nop, is_halt;
  logic        is_alu, is_mem;

  assign opc   = ir[31:27];
  assign ra_1h = 16'd1 << ir[26:23];
  assign rb_1h = 16'd1 << ir[22:19];
  assign rc_1h = 16'd1 << ir[18:15];

  assign is_rtype  = (opc <= 5'd11);
  assign is_muldiv = (opc == 5'b01110) || (opc == 5'b01111);
  assign is_ld     = (opc == 5'b10000);
  assign is_st     = (opc == 5'b10001);
  assign is_addi   = (opc == 5'b10010);
  assign is_nop    = (opc == 5'b11010);
  assign is_halt   = (opc == 5'b11011);
  assign is_alu    = is_rtype | is_muldiv;   // Y <= Rb, Z <= Y op Rc
  assign is_mem    = is_ld | is_st | is_addi; // Y <= base, Z <= Y + C

  // The low immediate bits go straight to the datapath through Cout.
  // This block does not use them.
  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (clear) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    reg_in    = '0;
    reg_out   = '0;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    Yin       = 1'b0;
    Zhighin   = 1'b0;
    Zlowin    = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IRin      = 1'b0;
    Cout      = 1'b0;
    BAOut     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    op        = '0;
    run       = 1'b1;
    illegal   = 1'b0;

    unique case (state)
      S_RST: state_nxt = S_T0;

      // The fetch strobes do not depend on stop. If T0 is followed by PAUSE,
      // Z has been loaded but PCin has not fired, so the later T0 redoes
      // the same PC+1.
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
        state_nxt = stop ? S_PAUSE : S_T1;
      end

      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_nxt = S_T2;
      end

      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        state_nxt = S_T3;
      end

      S_T3: begin
        if (is_alu) begin
          reg_out   = rb_1h;
          Yin       = 1'b1;
          state_nxt = S_T4;
        end else if (is_mem) begin
          // BAOut makes R0 read as zero, so that rb=0 gives absolute addressing.
          reg_out   = rb_1h;
          BAOut     = 1'b1;
          Yin       = 1'b1;
          state_nxt = S_T4;
        end else if (is_nop) begin
          state_nxt = S_T0;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          illegal   = 1'b1;
          state_nxt = ILLEGAL_AS_NOP ? S_T0 : S_HALT;
        end
      end

      S_T4: begin
        state_nxt = S_T0;
        if (is_alu) begin
          reg_out   = rc_1h;
          op        = opc;
          Zlowin    = 1'b1;
          Zhighin   = 1'b1;
          state_nxt = S_T5;
        end else if (is_mem) begin
          Cout      = 1'b1;
          op        = ALU_ADD;
          Zlowin    = 1'b1;
          state_nxt = S_T5;
        end
      end

      S_T5: begin
        state_nxt = S_T0;
        if (is_alu || is_mem) Zlowout = 1'b1;
        if (is_rtype || is_addi) begin
          reg_in = ra_1h;
        end else if (is_muldiv) begin
          LOin      = 1'b1;
          state_nxt = S_T6;
        end else if (is_ld || is_st) begin
          MARin     = 1'b1;
          state_nxt = S_T6;
        end
      end

      S_T6: begin
        state_nxt = S_T0;
        if (is_muldiv) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end else if (is_ld) begin
          Read      = 1'b1;
          MDRin     = 1'b1;
          state_nxt = S_T7;
        end else if (is_st) begin
          reg_out   = ra_1h;
          MDRin     = 1'b1;
          state_nxt = S_T7;
        end
      end

      S_T7: begin
        state_nxt = S_T0;
        if (is_ld) begin
          MDRout = 1'b1;
          reg_in = ra_1h;
        end else if (is_st) begin
          MDRout = 1'b1;
          Write  = 1'b1;
        end
      end

      S_PAUSE: begin
        run = 1'b0;
        if (!stop) state_nxt = S_T0;
      end

      S_HALT: run = 1'b0;

      default: state_nxt = S_RST;
    endcase
  end

endmodule
